// File: rtl/ifu_fetch_queue.sv
// Instruction fetch front end: issues sequential fetches, buffers in-order responses with their PCs,
// and on a redirect flushes the buffer and drops responses still in flight for the old stream.
module ifu_fetch_queue #(
    parameter int unsigned          CPU_WIDTH = 64,
    parameter int unsigned          INS_WIDTH = 32,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 64'h8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic                 o_mem_req_valid,
    output logic [CPU_WIDTH-1:0] o_mem_req_addr,
    input  logic                 i_mem_req_ready,
    input  logic                 i_mem_resp_valid,
    input  logic [INS_WIDTH-1:0] i_mem_resp_data,
    output logic                 o_if_valid,
    output logic [CPU_WIDTH-1:0] o_if_pc,
    output logic [INS_WIDTH-1:0] o_if_ins,
    input  logic                 i_id_ready,
    output logic                 o_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CPU_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CPU_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CPU_WIDTH-1:0] pc_mem_q [DEPTH];
    logic [INS_WIDTH-1:0] ins_mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
    logic                 err_q, err_d;

    logic [CW-1:0] live;
    logic [CW:0]   occupancy;
    logic          req_fire;
    logic          resp_live;
    logic          resp_drop;
    logic          push;
    logic          pop;

    // Requests are gated so every live response is guaranteed a FIFO slot.
    assign live            = inflight_q - drop_cnt_q;
    assign occupancy       = {1'b0, count_q} + {1'b0, live};
    assign o_mem_req_valid = !i_rst && !i_redirect && (inflight_q < CW'(DEPTH))
                             && (occupancy < (CW + 1)'(DEPTH));
    assign o_mem_req_addr  = fetch_pc_q;

    assign o_if_valid = (count_q != '0);
    assign o_if_pc    = pc_mem_q[rd_ptr_q];
    assign o_if_ins   = ins_mem_q[rd_ptr_q];
    assign o_err      = err_q;

    always_comb begin
        req_fire  = o_mem_req_valid && i_mem_req_ready;
        resp_live = i_mem_resp_valid && (inflight_q != '0);
        resp_drop = resp_live && (drop_cnt_q != '0);
        push      = resp_live && (drop_cnt_q == '0) && !i_redirect;
        pop       = o_if_valid && i_id_ready;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(resp_live);
        drop_cnt_d = drop_cnt_q - CW'(resp_drop);
        err_d      = err_q || (i_mem_resp_valid && (inflight_q == '0));

        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc;
            resp_pc_d  = i_redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight belongs to the old stream, less the one arriving now.
            drop_cnt_d = inflight_q - CW'(resp_live);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + CPU_WIDTH'(4);
            if (push) begin
                resp_pc_d = resp_pc_q + CPU_WIDTH'(4);
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]  <= RESET_PC;
                ins_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]  <= resp_pc_q;
                ins_mem_q[wr_ptr_q] <= i_mem_resp_data;
            end
        end
    end

endmodule
